// File: rtl/am_envelope_demod.sv
// AM envelope detector: |x| or x^2 -> moving average -> decimated DAC samples.
// Optional leaky DC tracker on the output, enabled with `AMD_DC_REMOVE_EN.
module am_envelope_demod #(
  parameter int DW       = 8,
  parameter int LOG2_LEN = 4,
  parameter int DECIM    = 1,
  parameter int DC_LOG2  = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          in_valid,
  input  logic [DW-1:0] ad_data,
  input  logic          mode,
  input  logic          clr,
  output logic [DW-1:0] da_data,
  output logic          out_valid
);

  localparam int N  = 1 << LOG2_LEN;
  localparam int SW = DW + LOG2_LEN;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DECIM - 1);

  logic [DW-1:0]          xu;
  logic signed [DW-1:0]   xs;
  logic [DW-1:0]          xa;
  logic signed [2*DW-1:0] sq;
  logic [DW-1:0]          d_n;
  logic [DW-1:0]          d_q;
  logic                   v1;
  logic                   v2;

  logic [DW-1:0]       mem [N];
  logic [LOG2_LEN-1:0] wp;
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_n;

  logic [DW-1:0] avg;
  logic [DW:0]   y2;
  logic [DW-1:0] y_n;
  logic [DW-1:0] y_q;
  logic          y_v;
  logic [CW-1:0] cnt;

  logic unused_bits;

  // Offset binary to two's complement is an MSB flip.
  always_comb begin
    xu  = ad_data ^ {1'b1, {(DW-1){1'b0}}};
    xs  = $signed(xu);
    xa  = xu[DW-1] ? (~xu + DW'(1)) : xu;
    sq  = xs * xs;
    d_n = mode ? sq[2*DW-2:DW-1] : xa;
  end

  assign unused_bits = ^{sq[2*DW-1], sq[DW-2:0]};

  always_comb begin
    sum_n = sum_q + SW'(d_q) - SW'(mem[wp]);
    avg   = sum_q[SW-1:LOG2_LEN];
    y2    = {avg, 1'b0};
    y_n   = y2[DW] ? {DW{1'b1}} : y2[DW-1:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      d_q   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      wp    <= '0;
      sum_q <= '0;
      cnt   <= '0;
      y_q   <= '0;
      y_v   <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (clr) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      wp    <= '0;
      sum_q <= '0;
      cnt   <= '0;
      y_v   <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) d_q <= d_n;
      v2 <= v1;
      if (v1) begin
        sum_q   <= sum_n;
        mem[wp] <= d_q;
        wp      <= wp + 1'b1;
      end
      y_v <= 1'b0;
      if (v2) begin
        if (cnt == CMAX) begin
          cnt <= '0;
          y_q <= y_n;
          y_v <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef AMD_DC_REMOVE_EN
  localparam int AW = DW + DC_LOG2;

  logic [AW-1:0]      acc;
  logic [DW-1:0]      dc;
  logic signed [DW+1:0] diff;
  logic [DW-1:0]      dac_n;
  logic [DW-1:0]      dac_q;
  logic               dac_v;

  always_comb begin
    dc   = acc[AW-1:DC_LOG2];
    diff = $signed({2'b00, y_q}) - $signed({2'b00, dc})
         + $signed((DW+2)'(1 << (DW-1)));
    if (diff[DW+1])   dac_n = '0;
    else if (diff[DW]) dac_n = {DW{1'b1}};
    else              dac_n = diff[DW-1:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc   <= '0;
      dac_q <= '0;
      dac_v <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      dac_v <= 1'b0;
    end else begin
      dac_v <= y_v;
      if (y_v) begin
        acc   <= acc + AW'(y_q) - AW'(dc);
        dac_q <= dac_n;
      end
    end
  end

  assign da_data   = dac_q;
  assign out_valid = dac_v;
`else
  assign da_data   = y_q;
  assign out_valid = y_v;
`endif

endmodule

// File: tb/tb_am_envelope_demod.sv
// Directed bench for am_envelope_demod (DECIM=1 and DECIM=4 instances).
module tb_am_envelope_demod;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] ad_data = 8'h00;
  logic [7:0] da_data;
  logic [7:0] da4;
  logic       out_valid;
  logic       ov4;

  int checks = 0;
  int failures = 0;
  int n1 = 0;
  int n4 = 0;

  always #5 sys_clk = ~sys_clk;

  am_envelope_demod #(.DW(8), .LOG2_LEN(4), .DECIM(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid),
    .ad_data(ad_data), .mode(mode), .clr(clr),
    .da_data(da_data), .out_valid(out_valid)
  );

  am_envelope_demod #(.DW(8), .LOG2_LEN(4), .DECIM(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid),
    .ad_data(ad_data), .mode(mode), .clr(clr),
    .da_data(da4), .out_valid(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    n1 += int'(out_valid);
    n4 += int'(ov4);
  endtask

  task automatic send(input logic [7:0] d, input logic m);
    in_valid = 1'b1;
    ad_data  = d;
    mode     = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    idle(2);
    chk("rst_da", da_data, 0);
    chk("rst_ov", out_valid, 0);
    sys_rst = 1'b0;
    tick();

    send(8'hFF, 1'b0);
    tick();
    chk("lat_t2_ov", out_valid, 0);
    tick();
    chk("lat_t3_ov", out_valid, 1);
    chk("first_da", da_data, 14);
    tick();
    chk("strobe_low", out_valid, 0);
    for (int i = 0; i < 15; i++) send(8'hFF, 1'b0);
    idle(2);
    chk("ff_ov", out_valid, 1);
    chk("ff_da", da_data, 254);
    tick();
    chk("ff_hold_ov", out_valid, 0);
    chk("ff_hold_da", da_data, 254);

    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_da", da_data, 0);
    chk("mid_rst_ov", out_valid, 0);
    tick();
    sys_rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) send(8'h00, 1'b0);
    idle(2);
    chk("sat_da", da_data, 255);
    send(8'h80, 1'b0);
    idle(2);
    chk("partial_da", da_data, 240);
    for (int i = 0; i < 15; i++) send(8'h80, 1'b0);
    idle(2);
    chk("zero_ov", out_valid, 1);
    chk("zero_da", da_data, 0);

    flush();
    chk("clr_ov", out_valid, 0);
    send(8'h00, 1'b1);
    idle(2);
    chk("sq_min_da", da_data, 16);
    flush();
    for (int i = 0; i < 8; i++) send(8'hC0, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h40, 1'b1);
    idle(2);
    chk("sq64_da", da_data, 64);
    for (int i = 0; i < 8; i++) begin
      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
    end
    idle(2);
    chk("alt_da", da_data, 254);

    clr      = 1'b1;
    in_valid = 1'b1;
    ad_data  = 8'hFF;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_ov", out_valid, 0);
    end
    chk("drop_hold_da", da_data, 254);
    send(8'hFF, 1'b0);
    idle(2);
    chk("drop_sum_da", da_data, 14);

    flush();
    clr      = 1'b1;
    in_valid = 1'b1;
    ad_data  = 8'hFF;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    n4 = 0;
    for (int i = 0; i < 3; i++) send(8'hFF, 1'b0);
    idle(3);
    chk("d4_three_cnt", n4, 0);
    send(8'hFF, 1'b0);
    idle(3);
    chk("d4_four_cnt", n4, 1);
    chk("d4_four_da", da4, 62);

    flush();
    n1 = 0;
    n4 = 0;
    for (int i = 0; i < 8; i++) send(8'hFF, 1'b0);
    idle(3);
    chk("d4_cnt", n4, 2);
    chk("d1_cnt", n1, 8);
    chk("d4_da", da4, 126);
    chk("d1_da", da_data, 126);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
